// File: rtl/nand3_ro_meter_pkg.sv
// Shared types and constants for the nand3_x0 ring-oscillator tap meter.
package nand3_ro_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned NSYNC_MIN = 2;

  // Widest supported count; narrower counters slice their all-ones value from here.
  localparam int unsigned CW_MAX   = 64;
  localparam logic [CW_MAX-1:0] CNT_ONES = {CW_MAX{1'b1}};

endpackage

// File: rtl/ro_sync.sv
// Multi-flop synchronizer for an asynchronous tap followed by a rising-edge detector.
module ro_sync
  import nand3_ro_meter_pkg::*;
#(
  parameter int unsigned NSYNC = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ro,
  output logic o_edge_c
);

  localparam int unsigned NS = (NSYNC < NSYNC_MIN) ? NSYNC_MIN : NSYNC;

  logic [NS-1:0] r_sync;
  logic          r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[NS-2:0], i_ro};
      r_prev <= r_sync[NS-1];
    end
  end

  assign o_edge_c = r_sync[NS-1] & ~r_prev;

endmodule

// File: rtl/nand3_ro_meter.sv
// Counts synchronized rising edges of a ring-oscillator tap over a programmed window.
module nand3_ro_meter
  import nand3_ro_meter_pkg::*;
#(
  parameter int unsigned CW    = 16,
  parameter int unsigned WW    = 16,
  parameter int unsigned NSYNC = 2
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          ro,
  input  logic          start,
  input  logic [WW-1:0] window,
  input  logic          ack,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count,
  output logic          ovf
);

  localparam logic [CW-1:0] CNT_MAX = CNT_ONES[CW-1:0];

  state_e        r_state;
  state_e        w_state_nxt;
  logic [WW-1:0] r_win;
  logic [WW-1:0] w_win_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_ovf;
  logic          w_ovf_nxt;
  logic          r_busy;
  logic          r_done;
  logic          w_edge;

  ro_sync #(
    .NSYNC(NSYNC)
  ) u_ro_sync (
    .i_clk    (ck),
    .i_rst    (rst),
    .i_ro     (ro),
    .o_edge_c (w_edge)
  );

  // State, window counter and result registers.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_win   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_busy  <= (w_state_nxt == ST_MEAS);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state logic; the window counter expiring at 1 gives exactly W MEAS cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
          if (window != '0) begin
            w_win_nxt   = window;
            w_state_nxt = ST_MEAS;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_MEAS: begin
        w_win_nxt = r_win - WW'(1);
        if (w_edge) begin
          if (r_count == CNT_MAX) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_count_nxt = r_count + CW'(1);
          end
        end
        if (r_win == WW'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign count = r_count;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_nand3_ro_meter.sv
// Randomized self-checking bench: two meter instances (CW=16 and CW=4) against a sample-history model.
module tb_nand3_ro_meter;

  localparam int NS   = 2;
  localparam int WW   = 16;
  localparam int HMAX = 20000;

  logic          ck;
  logic          rst;
  logic          ro;
  logic          start;
  logic [WW-1:0] window;
  logic          ack;
  logic          busy_a, done_a, ovf_a;
  logic [15:0]   count_a;
  logic          busy_b, done_b, ovf_b;
  logic [3:0]    count_b;

  int n_checks = 0;
  int n_errors = 0;
  int n_edge   = 0;
  int ro_mode  = 2;
  int ro_ph    = 0;
  bit hist [0:HMAX-1];

  nand3_ro_meter #(.CW(16), .WW(WW), .NSYNC(NS)) u_dut_a (
    .ck(ck), .rst(rst), .ro(ro), .start(start), .window(window), .ack(ack),
    .busy(busy_a), .done(done_a), .count(count_a), .ovf(ovf_a)
  );

  nand3_ro_meter #(.CW(4), .WW(WW), .NSYNC(NS)) u_dut_b (
    .ck(ck), .rst(rst), .ro(ro), .start(start), .window(window), .ack(ack),
    .busy(busy_b), .done(done_b), .count(count_b), .ovf(ovf_b)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Record what the first sync flop captures at each rising edge (0 while in reset).
  always @(posedge ck) begin
    if (n_edge < HMAX) hist[n_edge] = rst ? 1'b0 : ro;
    n_edge = n_edge + 1;
  end

  // ro changes only on falling edges: 0 random, 1 = ck/4 square wave, 2 = static high.
  always @(negedge ck) begin
    case (ro_mode)
      0: ro = 1'($urandom % 2);
      1: begin
        ro_ph = (ro_ph + 1) % 4;
        ro    = (ro_ph >= 2);
      end
      default: ro = 1'b1;
    endcase
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hs(input int j);
    return (j < 0) ? 1'b0 : hist[j];
  endfunction

  // Rises of ro samples whose pulse lands in MEAS cycles T+1..T+W, before saturation.
  function automatic int raw_count(input int t, input int w);
    int c = 0;
    for (int j = t - NS + 1; j <= t + w - NS; j++)
      if (hs(j) && !hs(j - 1)) c++;
    return c;
  endfunction

  task automatic check_results(input string tag, input int raw);
    chk({tag, "_cnt16"}, count_a, (raw > 65535) ? 65535 : raw);
    chk({tag, "_ovf16"}, ovf_a, (raw > 65535) ? 1 : 0);
    chk({tag, "_cnt4"}, count_b, (raw > 15) ? 15 : raw);
    chk({tag, "_ovf4"}, ovf_b, (raw > 15) ? 1 : 0);
  endtask

  // One complete start/measure/done/ack transaction with protocol noise.
  task automatic run_meas(input int w, input int fixed16, input bit noise);
    int t, lat, raw;
    bit both;
    window = WW'(w);
    start  = 1'b1;
    @(posedge ck); #1;
    t     = n_edge - 1;
    start = 1'b0;
    chk("busy_after_start", busy_a, (w != 0) ? 1 : 0);
    lat = 0;
    while (!done_a && lat < w + 4) begin
      if (noise) begin
        start  = ($urandom % 4 == 0);
        window = WW'($urandom % 8);
        ack    = ($urandom % 4 == 0);
      end
      @(posedge ck); #1;
      start = 1'b0;
      ack   = 1'b0;
      lat++;
    end
    chk("done_seen", done_a, 1);
    chk("latency", lat, w);
    chk("busy_in_done", busy_a, 0);
    chk("done4_sync", done_b, 1);
    raw = raw_count(t, w);
    check_results("res", raw);
    if (fixed16 >= 0) chk("fixed_cnt16", count_a, fixed16);
    // Hold in DONE; a lone start must not disturb it.
    for (int i = 0; i < int'($urandom % 3); i++) begin
      start  = noise && ($urandom % 2 == 0);
      window = WW'(5);
      @(posedge ck); #1;
      start = 1'b0;
      chk("done_hold", done_a, 1);
      chk("cnt_hold", count_a, (raw > 65535) ? 65535 : raw);
    end
    both  = noise && ($urandom % 2 == 0);
    ack   = 1'b1;
    start = both;
    @(posedge ck); #1;
    ack   = 1'b0;
    start = 1'b0;
    chk("done_after_ack", done_a, 0);
    chk("busy_after_ack", busy_a, 0);
    // Result persists in IDLE and stray acks are ignored.
    for (int i = 0; i < 2; i++) begin
      ack = noise && ($urandom % 2 == 0);
      @(posedge ck); #1;
      ack = 1'b0;
      chk("idle_busy", busy_a, 0);
      chk("idle_done", done_a, 0);
      chk("idle_cnt", count_a, (raw > 65535) ? 65535 : raw);
    end
  endtask

  initial begin
    rst    = 1'b1;
    ro     = 1'b1;
    start  = 1'b0;
    ack    = 1'b0;
    window = '0;
    #12;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_ovf", ovf_a, 0);
    @(posedge ck); #3;
    rst = 1'b0;
    repeat (6) @(posedge ck);
    #1;

    // ro held high through reset release.
    run_meas(10, 0, 1'b0);

    ro_mode = 1;
    repeat (3) @(posedge ck);
    #1;
    run_meas(100, 25, 1'b0);

    ro_mode = 0;
    run_meas(0, 0, 1'b0);

    ro_mode = 1;
    run_meas(160, 40, 1'b0);
    chk("sat_cnt4", count_b, 15);
    chk("sat_ovf4", ovf_b, 1);
    run_meas(8, 2, 1'b0);
    chk("post_sat_ovf4", ovf_b, 0);

    // Short windows at each phase of the square wave.
    for (int p = 0; p < 4; p++) begin
      repeat (p) @(posedge ck);
      #1;
      run_meas(1, -1, 1'b0);
      run_meas(2, -1, 1'b0);
    end

    // Reset halfway through a W=100 run.
    window = WW'(100);
    start  = 1'b1;
    @(posedge ck); #1;
    start = 1'b0;
    repeat (50) @(posedge ck);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_count", count_a, 0);
    chk("mid_rst_ovf", ovf_b, 0);
    repeat (2) @(posedge ck);
    #3;
    rst = 1'b0;
    repeat (5) @(posedge ck);
    #1;
    run_meas(20, 5, 1'b0);

    // Randomized transactions with protocol noise.
    for (int r = 0; r < 30; r++) begin
      int w;
      ro_mode = int'($urandom % 3);
      case ($urandom % 4)
        0: w = 0;
        1: w = 1;
        default: w = int'($urandom % 60);
      endcase
      repeat ($urandom % 3) @(posedge ck);
      #1;
      run_meas(w, -1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
